// File: rtl/ddr2_pkg.sv
// Shared command codes and address-generator FSM encoding for the DDR2 address path.
package ddr2_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWr   = 2'd1,
      StRd   = 2'd2
   } addr_state_e;

   // Width of an index into a ring of the given depth; never zero.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ring_ptr.sv
// Wrapping slot pointer for the burst ring; advances one slot per accepted command.
module ring_ptr #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned PTR_W = 10
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_adv,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   // Step to the next slot, returning to slot 0 after the last one so the ring has no gap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/ddr_addr_gen.sv
// DDR2 address FIFO command generator: turns write/read burst requests into
// ring-addressed controller commands, keeping reads behind the writes they consume.
module ddr_addr_gen
   import ddr2_pkg::*;
#(
   parameter int unsigned     ADDR_WIDTH    = 31,
   parameter int unsigned     WRITE_BURST   = 8,
   parameter int unsigned     REGION_BURSTS = 1024,
   parameter longint unsigned BASE_ADDR     = 0
) (
   input  logic                         sys_clk,
   input  logic                         reset_n,
   input  logic                         wr_addr_en,
   input  logic                         rd_addr_en,
   input  logic                         app_af_afull,
   output logic                         app_af_wren,
   output logic [2:0]                   app_af_cmd,
   output logic [ADDR_WIDTH-1:0]        app_af_addr,
   output logic                         addr_confilct,
   output logic                         full,
   output logic [$clog2(REGION_BURSTS):0] level,
   output logic                         overflow
);

   localparam int unsigned PTR_W = ptr_width(REGION_BURSTS);
   localparam int unsigned LVL_W = $clog2(REGION_BURSTS) + 1;
   localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [LVL_W-1:0]      LVL_MAX = LVL_W'(REGION_BURSTS);

   addr_state_e           r_state;
   logic                  r_wr_pend;
   logic                  r_rd_pend;
   logic                  r_overflow;
   logic                  r_wren;
   logic [2:0]            r_cmd;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LVL_W-1:0]      r_level;
   logic                  r_conflict;
   logic                  r_full;

   logic                  w_wr_elig;
   logic                  w_rd_elig;
   logic                  w_wr_go;
   logic                  w_rd_go;
   logic [PTR_W-1:0]      w_wr_ptr;
   logic [PTR_W-1:0]      w_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [LVL_W-1:0]      w_level_d;

   // Reads need a burst already in the ring; everything stalls while the controller FIFO is nearly full.
   assign w_wr_elig = r_wr_pend & ~r_full & ~app_af_afull;
   assign w_rd_elig = r_rd_pend & (r_level != '0) & ~app_af_afull;

   assign w_wr_addr = BASE + ADDR_WIDTH'(w_wr_ptr) * ADDR_WIDTH'(WRITE_BURST);
   assign w_rd_addr = BASE + ADDR_WIDTH'(w_rd_ptr) * ADDR_WIDTH'(WRITE_BURST);

   // Next-command decode: right after a write the read gets first claim, otherwise writes win.
   always_comb begin
      w_wr_go = 1'b0;
      w_rd_go = 1'b0;
      if (r_state == StWr) begin
         w_rd_go = w_rd_elig;
         w_wr_go = w_wr_elig & ~w_rd_elig;
      end else begin
         w_wr_go = w_wr_elig;
         w_rd_go = w_rd_elig & ~w_wr_elig;
      end
   end

   // Ring occupancy moves by exactly one per issued command.
   always_comb begin
      w_level_d = r_level;
      if (w_wr_go) begin
         w_level_d = r_level + LVL_W'(1);
      end else if (w_rd_go) begin
         w_level_d = r_level - LVL_W'(1);
      end
   end

   ring_ptr #(
      .DEPTH (REGION_BURSTS),
      .PTR_W (PTR_W)
   ) u_wr_ptr (
      .i_clk   (sys_clk),
      .i_rst_n (reset_n),
      .i_adv   (w_wr_go),
      .o_ptr   (w_wr_ptr)
   );

   ring_ptr #(
      .DEPTH (REGION_BURSTS),
      .PTR_W (PTR_W)
   ) u_rd_ptr (
      .i_clk   (sys_clk),
      .i_rst_n (reset_n),
      .i_adv   (w_rd_go),
      .o_ptr   (w_rd_ptr)
   );

   // FSM with registered command outputs; idle cycles hold the last command and address.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_wren  <= 1'b0;
         r_cmd   <= CMD_WR;
         r_addr  <= BASE;
      end else if (w_wr_go) begin
         r_state <= StWr;
         r_wren  <= 1'b1;
         r_cmd   <= CMD_WR;
         r_addr  <= w_wr_addr;
      end else if (w_rd_go) begin
         r_state <= StRd;
         r_wren  <= 1'b1;
         r_cmd   <= CMD_RD;
         r_addr  <= w_rd_addr;
      end else begin
         r_state <= StIdle;
         r_wren  <= 1'b0;
      end
   end

   // A fresh pulse always leaves its flag set; a pulse onto a flag that is not draining is lost.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_pend  <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (wr_addr_en) begin
            r_wr_pend <= 1'b1;
         end else if (w_wr_go) begin
            r_wr_pend <= 1'b0;
         end
         if (rd_addr_en) begin
            r_rd_pend <= 1'b1;
         end else if (w_rd_go) begin
            r_rd_pend <= 1'b0;
         end
         r_overflow <= r_overflow
                     | (wr_addr_en & r_wr_pend & ~w_wr_go)
                     | (rd_addr_en & r_rd_pend & ~w_rd_go);
      end
   end

   // Occupancy and its empty/full flags are registered together so they never disagree.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level    <= '0;
         r_conflict <= 1'b1;
         r_full     <= 1'b0;
      end else begin
         r_level    <= w_level_d;
         r_conflict <= (w_level_d == '0);
         r_full     <= (w_level_d == LVL_MAX);
      end
   end

   assign app_af_wren   = r_wren;
   assign app_af_cmd    = r_cmd;
   assign app_af_addr   = r_addr;
   assign addr_confilct = r_conflict;
   assign full          = r_full;
   assign level         = r_level;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_ddr_addr_gen.sv
// Self-checking bench for ddr_addr_gen: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an integer reference model.
module tb_ddr_addr_gen;

   localparam int unsigned     AW   = 31;
   localparam int unsigned     WB   = 8;
   localparam int              RB   = 4;
   localparam longint unsigned BASE = 0;

   logic          sys_clk      = 1'b0;
   logic          reset_n      = 1'b0;
   logic          wr_addr_en   = 1'b0;
   logic          rd_addr_en   = 1'b0;
   logic          app_af_afull = 1'b0;
   logic          app_af_wren;
   logic [2:0]    app_af_cmd;
   logic [AW-1:0] app_af_addr;
   logic          addr_confilct;
   logic          full;
   logic [2:0]    level;
   logic          overflow;

   int n_cmp = 0;
   int n_bad = 0;

   ddr_addr_gen #(
      .ADDR_WIDTH    (AW),
      .WRITE_BURST   (WB),
      .REGION_BURSTS (RB),
      .BASE_ADDR     (BASE)
   ) dut (
      .sys_clk       (sys_clk),
      .reset_n       (reset_n),
      .wr_addr_en    (wr_addr_en),
      .rd_addr_en    (rd_addr_en),
      .app_af_afull  (app_af_afull),
      .app_af_wren   (app_af_wren),
      .app_af_cmd    (app_af_cmd),
      .app_af_addr   (app_af_addr),
      .addr_confilct (addr_confilct),
      .full          (full),
      .level         (level),
      .overflow      (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: ring occupancy and slot indices as plain integers.
   int     m_level   = 0;
   int     m_wrp     = 0;
   int     m_rdp     = 0;
   bit     m_wp      = 1'b0;
   bit     m_rp      = 1'b0;
   bit     m_last_wr = 1'b0;
   bit     m_wren    = 1'b0;
   bit     m_ovf     = 1'b0;
   int     m_cmd     = 0;
   longint m_addr    = longint'(BASE);

   always @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         m_level = 0; m_wrp = 0; m_rdp = 0;
         m_wp = 1'b0; m_rp = 1'b0; m_last_wr = 1'b0;
         m_wren = 1'b0; m_ovf = 1'b0; m_cmd = 0; m_addr = longint'(BASE);
      end else begin
         bit can_w, can_r, do_w, do_r;
         can_w = m_wp && (m_level < RB) && !app_af_afull;
         can_r = m_rp && (m_level > 0) && !app_af_afull;
         if (m_last_wr) begin
            do_r = can_r;
            do_w = can_w && !can_r;
         end else begin
            do_w = can_w;
            do_r = can_r && !can_w;
         end
         if (wr_addr_en && m_wp && !do_w) m_ovf = 1'b1;
         if (rd_addr_en && m_rp && !do_r) m_ovf = 1'b1;
         if (do_w) begin
            m_wren = 1'b1; m_cmd = 0;
            m_addr = longint'(BASE) + longint'(m_wrp) * longint'(WB);
            m_wrp = (m_wrp + 1) % RB; m_level++; m_wp = 1'b0;
         end else if (do_r) begin
            m_wren = 1'b1; m_cmd = 1;
            m_addr = longint'(BASE) + longint'(m_rdp) * longint'(WB);
            m_rdp = (m_rdp + 1) % RB; m_level--; m_rp = 1'b0;
         end else begin
            m_wren = 1'b0;
         end
         if (wr_addr_en) m_wp = 1'b1;
         if (rd_addr_en) m_rp = 1'b1;
         m_last_wr = do_w;
      end
   end

   function automatic logic [63:0] pack(input logic w, input logic [2:0] c, input logic [AW-1:0] a,
                                        input logic [2:0] l, input logic cf, input logic fl,
                                        input logic ov);
      return 64'({w, c, a, l, cf, fl, ov});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (wren,cmd,addr,level,conflict,full,ovf)",
                  name, act, exp);
      end
   endtask

   task automatic expect_out(input string name, input bit w, input int c, input longint a,
                             input int l, input bit cf, input bit fl, input bit ov);
      check(name, pack(app_af_wren, app_af_cmd, app_af_addr, level, addr_confilct, full, overflow),
            pack(w, 3'(c), AW'(a), 3'(l), cf, fl, ov));
   endtask

   task automatic expect_wren(input string name, input bit w);
      check(name, 64'(app_af_wren), 64'(w));
   endtask

   // Every cycle out of reset the DUT must match the model.
   always @(negedge sys_clk) begin
      if (reset_n) begin
         check("model", pack(app_af_wren, app_af_cmd, app_af_addr, level, addr_confilct, full,
                             overflow),
               pack(m_wren, 3'(m_cmd), AW'(m_addr), 3'(m_level), m_level == 0, m_level == RB,
                    m_ovf));
      end
   end

   task automatic next_cycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; wr_addr_en = 1'b0; rd_addr_en = 1'b0; app_af_afull = 1'b0;
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset values
      do_reset();
      expect_out("reset", 0, 0, 0, 0, 1, 0, 0);

      // Single write: two-cycle latency
      wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; expect_wren("single c1", 0);
      next_cycle(); expect_out("single c2", 1, 0, 0, 1, 0, 0, 0);

      // Simultaneous requests at level 1: write first, then read
      next_cycle();
      wr_addr_en = 1'b1; rd_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; rd_addr_en = 1'b0;
      next_cycle(); expect_out("simul wr", 1, 0, 8, 2, 0, 0, 0);
      next_cycle(); expect_out("simul rd", 1, 1, 0, 1, 0, 0, 0);
      next_cycle(); expect_out("simul idle", 0, 1, 0, 1, 0, 0, 0);

      // Read on empty waits for a write
      do_reset();
      rd_addr_en = 1'b1;
      next_cycle(); rd_addr_en = 1'b0;
      next_cycle(); expect_out("empty rd held", 0, 0, 0, 0, 1, 0, 0);
      next_cycle(); wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; expect_wren("empty c4", 0);
      next_cycle(); expect_out("empty wr", 1, 0, 0, 1, 0, 0, 0);
      next_cycle(); expect_out("empty rd", 1, 1, 0, 0, 1, 0, 0);
      next_cycle(); expect_wren("empty done", 0);

      // Backpressure: afull high for 10 cycles
      do_reset();
      app_af_afull = 1'b1; wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         expect_wren("afull hold", 0);
         next_cycle();
      end
      app_af_afull = 1'b0; expect_wren("afull c10", 0);
      next_cycle(); expect_out("afull release", 1, 0, 0, 1, 0, 0, 0);

      // Fill to full, hold a fifth write, drain one, wrapped write at slot 0
      do_reset();
      wr_addr_en = 1'b1;
      repeat (4) next_cycle();
      wr_addr_en = 1'b0;
      expect_out("fill 3", 1, 0, 16, 3, 0, 0, 0);
      next_cycle(); expect_out("full", 1, 0, 24, 4, 0, 1, 0);
      next_cycle(); wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; expect_out("fifth held", 0, 0, 24, 4, 0, 1, 0);
      next_cycle(); expect_wren("fifth held c8", 0); rd_addr_en = 1'b1;
      next_cycle(); rd_addr_en = 1'b0; expect_wren("rd pend c9", 0);
      next_cycle(); expect_out("read at full", 1, 1, 0, 3, 0, 0, 0);
      next_cycle(); expect_out("wrap write", 1, 0, 0, 4, 0, 1, 0);
      next_cycle(); expect_wren("wrap idle", 0);

      // Overflow: second pulse onto a held flag is dropped
      do_reset();
      app_af_afull = 1'b1; wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0;
      next_cycle(); wr_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; expect_out("overflow", 0, 0, 0, 0, 1, 0, 1);
      app_af_afull = 1'b0;
      next_cycle(); expect_out("ovf write", 1, 0, 0, 1, 0, 0, 1);
      next_cycle(); expect_out("ovf single", 0, 0, 0, 1, 0, 0, 1);

      // Asynchronous reset with both flags pending
      do_reset();
      wr_addr_en = 1'b1;
      next_cycle();
      next_cycle(); wr_addr_en = 1'b0;
      next_cycle();
      next_cycle(); app_af_afull = 1'b1; wr_addr_en = 1'b1; rd_addr_en = 1'b1;
      next_cycle(); wr_addr_en = 1'b0; rd_addr_en = 1'b0;
      expect_out("pre reset", 0, 0, 8, 2, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1 expect_out("async reset", 0, 0, 0, 0, 1, 0, 0);
      next_cycle(); app_af_afull = 1'b0; reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         expect_out("post reset", 0, 0, 0, 0, 1, 0, 0);
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         wr_addr_en = ($urandom_range(0, 99) < 35);
         rd_addr_en = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 9) == 0) app_af_afull = ~app_af_afull;
         next_cycle();
      end
      wr_addr_en = 1'b0; rd_addr_en = 1'b0; app_af_afull = 1'b0;
      repeat (8) next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
